fb_mem_arbiter: RTL

Framebuffer memory arbiter and display-fetch scheduler for the 640x480@60 VGA path. It shares one single-port synchronous RAM between two users. Display scan-out gets fixed, guaranteed read slots derived from the sync generator's CounterX/CounterY. A host port (CPU or drawing engine) gets every remaining cycle for reads and writes. The framebuffer is 160x120 words, and each word covers a 4x4 block of screen pixels.

---
 rtl/fb_mem_arbiter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/fb_mem_arbiter.sv
// fb_mem_arbiter
//   Shares one single-port synchronous framebuffer RAM (160x120 words, one
//   word per 4x4 pixel block) between VGA display scan-out and a host port.
//   Display reads take fixed slots derived from CounterX/CounterY. The host
//   gets every remaining cycle, at a peak rate of one op every 2 cycles.
//
//   Optional feature macro: FB_RANGE_CHECK_EN
//     defined   : host_addr >= 19200 is still granted. A write is suppressed
//                 and a read returns 0.
//     undefined : host_addr goes to the RAM unchanged and a read returns the
//                 raw mem_rdata.
//
// Ports
//   CLK_25               25 MHz pixel clock
//   Reset                asynchronous active-low reset
//   CounterX/CounterY    sync generator counters
//   host_req/we/addr/wdata  host request, held until host_gnt
//   host_gnt             pulse: host op issued to the RAM this cycle
//   host_rvalid/rdata    host read return, arriving 2 cycles after host_gnt
//   mem_addr/we/wdata    registered RAM controls
//   mem_rdata            RAM read data, one cycle after its address
//   pix_data/pix_valid   display word, 3 cycles after its slot
module fb_mem_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 15
) (
  input  logic              CLK_25,
  input  logic              Reset,
  input  logic [9:0]        CounterX,
  input  logic [9:0]        CounterY,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid
);

  typedef enum logic {S_IDLE = 1'b0, S_GNT = 1'b1} state_t;

  state_t state_q, state_d;

  logic              slot;
  logic [ADDR_W-1:0] y_ext, x_ext, disp_addr;
  logic              host_acc;
  logic              host_oor;

  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  // Tag pipeline. Stage 1 lines up with mem_addr, stage 2 with mem_rdata.
  logic t1_v_q, t1_v_d, t1_host_q, t1_host_d, t1_oor_q, t1_oor_d;
  logic t2_v_q, t2_host_q, t2_oor_q;

  logic              host_rvalid_q, host_rvalid_d;
  logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
  logic              pix_valid_q, pix_valid_d;
  logic [DATA_W-1:0] pix_data_q, pix_data_d;

  // A display slot is every 4th pixel of the active area. x and y are the
  // block coordinates, and the word address is y*160 + x computed by shift-add.
  always_comb begin
    slot      = (CounterX < 10'd640) && (CounterY < 10'd480) && (CounterX[1:0] == 2'b00);
    y_ext     = ADDR_W'(CounterY[9:2]);
    x_ext     = ADDR_W'(CounterX[9:2]);
    disp_addr = (y_ext << 7) + (y_ext << 5) + x_ext;
  end

`ifdef FB_RANGE_CHECK_EN
  localparam logic [ADDR_W-1:0] FB_WORDS = ADDR_W'(19200);
  assign host_oor = (host_addr >= FB_WORDS);
`else
  assign host_oor = 1'b0;
`endif

  // Host FSM: state register
  always_ff @(posedge CLK_25 or negedge Reset) begin
    if (!Reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Host FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (host_req && !slot) state_d = S_GNT;
      S_GNT:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Host FSM: outputs. GNT ignores host_req, so a request that is still
  // held is not issued a second time.
  always_comb begin
    host_acc = (state_q == S_IDLE) && host_req && !slot;
    host_gnt = (state_q == S_GNT);
  end

  // Issue and read-back steering
  always_comb begin
    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    t1_v_d      = 1'b0;
    t1_host_d   = 1'b0;
    t1_oor_d    = 1'b0;
    if (slot) begin
      mem_addr_d = disp_addr;
      t1_v_d     = 1'b1;
    end else if (host_acc) begin
      mem_addr_d  = host_addr;
      mem_we_d    = host_we && !host_oor;
      mem_wdata_d = host_wdata;
      t1_v_d      = !host_we;
      t1_host_d   = 1'b1;
      t1_oor_d    = host_oor;
    end

    host_rvalid_d = t2_v_q && t2_host_q;
    pix_valid_d   = t2_v_q && !t2_host_q;
    host_rdata_d  = host_rdata_q;
    pix_data_d    = pix_data_q;
    if (host_rvalid_d) host_rdata_d = t2_oor_q ? '0 : mem_rdata;
    if (pix_valid_d)   pix_data_d   = mem_rdata;
  end

  always_ff @(posedge CLK_25 or negedge Reset) begin
    if (!Reset) begin
      mem_addr_q    <= '0;
      mem_we_q      <= 1'b0;
      mem_wdata_q   <= '0;
      t1_v_q        <= 1'b0;
      t1_host_q     <= 1'b0;
      t1_oor_q      <= 1'b0;
      t2_v_q        <= 1'b0;
      t2_host_q     <= 1'b0;
      t2_oor_q      <= 1'b0;
      host_rvalid_q <= 1'b0;
      host_rdata_q  <= '0;
      pix_valid_q   <= 1'b0;
      pix_data_q    <= '0;
    end else begin
      mem_addr_q    <= mem_addr_d;
      mem_we_q      <= mem_we_d;
      mem_wdata_q   <= mem_wdata_d;
      t1_v_q        <= t1_v_d;
      t1_host_q     <= t1_host_d;
      t1_oor_q      <= t1_oor_d;
      t2_v_q        <= t1_v_q;
      t2_host_q     <= t1_host_q;
      t2_oor_q      <= t1_oor_q;
      host_rvalid_q <= host_rvalid_d;
      host_rdata_q  <= host_rdata_d;
      pix_valid_q   <= pix_valid_d;
      pix_data_q    <= pix_data_d;
    end
  end

  assign mem_addr    = mem_addr_q;
  assign mem_we      = mem_we_q;
  assign mem_wdata   = mem_wdata_q;
  assign host_rvalid = host_rvalid_q;
  assign host_rdata  = host_rdata_q;
  assign pix_valid   = pix_valid_q;
  assign pix_data    = pix_data_q;

endmodule
